// File: rtl/rf_param_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_param_sb_if
//  Description : Bus bundle for rf_param_sb: two read ports, one writeback
//                port, one reserve (issue) port and the scoreboard status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_param_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read_enabled;
    logic [ADDR_WIDTH-1:0] read_addr_s;
    logic [ADDR_WIDTH-1:0] read_addr_t;
    logic                  write_enabled;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reserve_enabled;
    logic [ADDR_WIDTH-1:0] reserve_addr;
    logic [DATA_WIDTH-1:0] outA;
    logic [DATA_WIDTH-1:0] outB;
    logic                  busy_s;
    logic                  busy_t;
    logic                  hazard;

    // Pipeline side: issues reads, writebacks and reservations
    modport master (
        output read_enabled, read_addr_s, read_addr_t,
        output write_enabled, write_addr, write_data,
        output reserve_enabled, reserve_addr,
        input  outA, outB, busy_s, busy_t, hazard
    );

    // Register file side
    modport slave (
        input  read_enabled, read_addr_s, read_addr_t,
        input  write_enabled, write_addr, write_data,
        input  reserve_enabled, reserve_addr,
        output outA, outB, busy_s, busy_t, hazard
    );
endinterface
`default_nettype wire

// File: rtl/rf_param_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_param_sb
//  Description : Parametrised register file, two registered read ports, one
//                write port, with a per-register pending-write scoreboard
//                that reports read-after-write hazards.
//                Optional macro REGFILE_BYPASS_EN: write-through forwarding
//                to the read ports and masking of busy/hazard for the
//                forwarded address.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_param_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  wire logic     clock,
    input  wire logic     reset_n,
    rf_param_sb_if.slave  bus
);
    localparam int DEPTH       = 1 << ADDR_WIDTH;
    localparam bit C_ZERO_REG  = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pending;
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;

    logic                  w_write_ok;
    logic                  w_reserve_ok;
    logic [DEPTH-1:0]      w_set_mask;
    logic [DEPTH-1:0]      w_clr_mask;
    logic                  w_zero_s;
    logic                  w_zero_t;
    logic                  w_fwd_s;
    logic                  w_fwd_t;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  w_busy_s;
    logic                  w_busy_t;

    // Index 0 is hardwired to zero when ZERO_REG is set: drop writes and reservations to it
    assign w_write_ok   = bus.write_enabled   && !(C_ZERO_REG && (bus.write_addr   == '0));
    assign w_reserve_ok = bus.reserve_enabled && !(C_ZERO_REG && (bus.reserve_addr == '0));
    assign w_zero_s     = C_ZERO_REG && (bus.read_addr_s == '0);
    assign w_zero_t     = C_ZERO_REG && (bus.read_addr_t == '0);

`ifdef REGFILE_BYPASS_EN
    assign w_fwd_s = bus.write_enabled && (bus.write_addr == bus.read_addr_s);
    assign w_fwd_t = bus.write_enabled && (bus.write_addr == bus.read_addr_t);
`else
    assign w_fwd_s = 1'b0;
    assign w_fwd_t = 1'b0;
`endif

    // One-hot set/clear masks for the scoreboard update
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_reserve_ok) begin
            w_set_mask[bus.reserve_addr] = 1'b1;
        end
        if (bus.write_enabled) begin
            w_clr_mask[bus.write_addr] = 1'b1;
        end
    end

    // Read data selection: zero register, optional forwarding, else stored value
    always_comb begin
        w_rd_a = r_regs[bus.read_addr_s];
        w_rd_b = r_regs[bus.read_addr_t];
        if (w_fwd_s) begin
            w_rd_a = bus.write_data;
        end
        if (w_fwd_t) begin
            w_rd_b = bus.write_data;
        end
        if (w_zero_s) begin
            w_rd_a = '0;
        end
        if (w_zero_t) begin
            w_rd_b = '0;
        end
    end

    // Register array: cleared on reset, written on writeback strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_ok) begin
            r_regs[bus.write_addr] <= bus.write_data;
        end
    end

    // Scoreboard: a new reservation overrides a same-edge writeback clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    // Registered read ports, hold when read_enabled is low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_a <= '0;
            r_out_b <= '0;
        end else if (bus.read_enabled) begin
            r_out_a <= w_rd_a;
            r_out_b <= w_rd_b;
        end
    end

    // Forwarded addresses are not hazards: their data arrives this edge
    assign w_busy_s = r_pending[bus.read_addr_s] && !w_fwd_s;
    assign w_busy_t = r_pending[bus.read_addr_t] && !w_fwd_t;

    assign bus.outA   = r_out_a;
    assign bus.outB   = r_out_b;
    assign bus.busy_s = w_busy_s;
    assign bus.busy_t = w_busy_t;
    assign bus.hazard = bus.read_enabled && (w_busy_s || w_busy_t);

endmodule
`default_nettype wire

// File: tb/tb_rf_param_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_param_sb
//  Description : Scoreboard bench for rf_param_sb. Drives two instances in
//                lock-step: 32x32 with ZERO_REG=1 and 16x8 with ZERO_REG=0.
//                Honours REGFILE_BYPASS_EN for the expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_param_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_A  = 0;
    localparam int K_B  = 1;
    localparam int K_BS = 2;
    localparam int K_BT = 3;
    localparam int K_HZ = 4;

    typedef struct {
        int          dut;
        int          kind;
        int          due;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic  clock;
    logic  reset_n;
    int    cyc;
    int    checks;
    int    errors;
    item_t sb[$];

    rf_param_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
    rf_param_sb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus1 ();

    rf_param_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    rf_param_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench cycle counter used to schedule when each expectation is due
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int dut, input int kind);
        logic [31:0] v;
        v = '0;
        if (dut == 0) begin
            case (kind)
                K_A:     v = bus0.outA;
                K_B:     v = bus0.outB;
                K_BS:    v = {31'd0, bus0.busy_s};
                K_BT:    v = {31'd0, bus0.busy_t};
                default: v = {31'd0, bus0.hazard};
            endcase
        end else begin
            case (kind)
                K_A:     v = {16'd0, bus1.outA};
                K_B:     v = {16'd0, bus1.outB};
                K_BS:    v = {31'd0, bus1.busy_s};
                K_BT:    v = {31'd0, bus1.busy_t};
                default: v = {31'd0, bus1.hazard};
            endcase
        end
        return v;
    endfunction

    // Monitor: on the falling edge, compare every expectation that has come due
    always @(negedge clock) begin
        item_t it;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it  = sb.pop_front();
            act = actual(it.dut, it.kind);
            checks = checks + 1;
            if (act !== it.exp) begin
                errors = errors + 1;
                $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                         it.name, it.dut, cyc, act, it.exp);
            end
        end
    end

    task automatic push(input int dut, input int kind, input int delay,
                        input logic [31:0] exp, input string name);
        item_t it;
        it.dut  = dut;
        it.kind = kind;
        it.due  = cyc + delay;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic expect2(input int kind, input int delay, input logic [31:0] e0,
                           input logic [31:0] e1, input string name);
        push(0, kind, delay, e0, name);
        push(1, kind, delay, e1, name);
    endtask

    task automatic drive(input bit re, input logic [4:0] s, input logic [4:0] t,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit rv, input logic [4:0] ra);
        bus0.read_enabled    = re;
        bus0.read_addr_s     = s;
        bus0.read_addr_t     = t;
        bus0.write_enabled   = we;
        bus0.write_addr      = wa;
        bus0.write_data      = wd;
        bus0.reserve_enabled = rv;
        bus0.reserve_addr    = ra;
        bus1.read_enabled    = re;
        bus1.read_addr_s     = s[2:0];
        bus1.read_addr_t     = t[2:0];
        bus1.write_enabled   = we;
        bus1.write_addr      = wa[2:0];
        bus1.write_data      = wd[15:0];
        bus1.reserve_enabled = rv;
        bus1.reserve_addr    = ra[2:0];
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus; expectations pushed as each vector is issued
    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        // reset state
        expect2(K_A,  0, 32'h0, 32'h0, "reset_outA");
        expect2(K_B,  0, 32'h0, 32'h0, "reset_outB");
        expect2(K_BS, 0, 32'h0, 32'h0, "reset_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h0, "reset_busy_t");
        expect2(K_HZ, 0, 32'h0, 32'h0, "reset_hazard");
        step();
        // write reg 3, read it back
        drive(1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_A, 1, 32'hDEADBEEF, 32'h0000BEEF, "read_r3");
        expect2(K_B, 1, 32'h0, 32'h0, "read_r0");
        step();
        idle();
        step();
        // asynchronous reset mid-stream with a write and reserve in flight
        drive(1'b1, 5'd4, 5'd0, 1'b1, 5'd3, 32'h11112222, 1'b1, 5'd4);
        reset_n = 1'b0;
        expect2(K_A,  0, 32'h0, 32'h0, "async_reset_outA");
        expect2(K_B,  0, 32'h0, 32'h0, "async_reset_outB");
        expect2(K_BS, 0, 32'h0, 32'h0, "async_reset_busy_s");
        expect2(K_HZ, 0, 32'h0, 32'h0, "async_reset_hazard");
        step();
        reset_n = 1'b1;
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h0, 32'h0, "post_reset_busy_s");
        expect2(K_HZ, 0, 32'h0, 32'h0, "post_reset_hazard");
        expect2(K_A,  1, 32'h0, 32'h0, "post_reset_r3");
        expect2(K_B,  1, 32'h0, 32'h0, "post_reset_r0");
        step();
        drive(1'b1, 5'd4, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h0, 32'h0, "reserve_discarded_busy");
        expect2(K_HZ, 0, 32'h0, 32'h0, "reserve_discarded_hazard");
        expect2(K_A,  1, 32'h0, 32'h0, "post_reset_r4");
        expect2(K_B,  1, 32'h0, 32'h0, "write_discarded_r3");
        step();
        // zero register
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_A, 1, 32'h0, 32'h00005678, "zero_reg_outA");
        expect2(K_B, 1, 32'h0, 32'h00005678, "zero_reg_outB");
        step();
        // scoreboard: reserve 5, observe hazard, write back, hazard gone
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        step();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h1, 32'h1, "pending5_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h0, "pending5_busy_t");
        expect2(K_HZ, 0, 32'h1, 32'h1, "pending5_hazard");
        expect2(K_A,  1, 32'h0, 32'h0, "pending5_outA");
        expect2(K_B,  1, 32'h0, 32'h00005678, "pending5_outB");
        step();
        drive(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0);
        expect2(K_BS, 0, BYP ? 32'h0 : 32'h1, BYP ? 32'h0 : 32'h1, "writeback5_busy_s");
        expect2(K_HZ, 0, 32'h0, 32'h0, "writeback5_hazard_noread");
        step();
        drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h0, 32'h0, "cleared5_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h0, "cleared5_busy_t");
        expect2(K_HZ, 0, 32'h0, 32'h0, "cleared5_hazard");
        expect2(K_A,  1, 32'hA5A5A5A5, 32'h0000A5A5, "read5_outA");
        expect2(K_B,  1, 32'hA5A5A5A5, 32'h0000A5A5, "read5_outB");
        step();
        // simultaneous reserve and write of 7: set wins, data stored
        drive(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7);
        expect2(K_BS, 0, 32'h0, 32'h0, "pre_setclr7_busy_s");
        step();
        drive(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h1, 32'h1, "setwins7_busy_s");
        expect2(K_BT, 0, 32'h1, 32'h1, "setwins7_busy_t");
        expect2(K_HZ, 0, 32'h1, 32'h1, "setwins7_hazard");
        expect2(K_A,  1, 32'h1, 32'h1, "setwins7_outA");
        expect2(K_B,  1, 32'h1, 32'h1, "setwins7_outB");
        step();
        // different indices on the same edge: clear 7, set 2
        drive(1'b0, 5'd7, 5'd2, 1'b1, 5'd7, 32'h77, 1'b1, 5'd2);
        expect2(K_BS, 0, BYP ? 32'h0 : 32'h1, BYP ? 32'h0 : 32'h1, "diffidx_busy_s_before");
        expect2(K_BT, 0, 32'h0, 32'h0, "diffidx_busy_t_before");
        step();
        drive(1'b1, 5'd7, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h0, 32'h0, "diffidx_clear7");
        expect2(K_BT, 0, 32'h1, 32'h1, "diffidx_set2");
        expect2(K_HZ, 0, 32'h1, 32'h1, "diffidx_hazard");
        expect2(K_A,  1, 32'h77, 32'h77, "diffidx_outA");
        expect2(K_B,  1, 32'h0, 32'h0, "diffidx_outB");
        step();
        // reserve index 0 (ignored only when ZERO_REG=1)
        drive(1'b0, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        expect2(K_BS, 0, 32'h1, 32'h1, "pending2_busy_s");
        step();
        // read 0 and 2 while re-reserving already pending 2
        drive(1'b1, 5'd0, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
        expect2(K_BS, 0, 32'h0, 32'h1, "reserve0_busy_s");
        expect2(K_BT, 0, 32'h1, 32'h1, "pending2_busy_t");
        expect2(K_HZ, 0, 32'h1, 32'h1, "reserve0_hazard");
        expect2(K_A,  1, 32'h0, 32'h00005678, "reserve0_outA");
        expect2(K_B,  1, 32'h0, 32'h0, "reserve0_outB");
        step();
        // 2 still pending after re-reserve; reserve+write 9 = 0x11
        drive(1'b1, 5'd2, 5'd0, 1'b1, 5'd9, 32'h11, 1'b1, 5'd9);
        expect2(K_BS, 0, 32'h1, 32'h1, "rereserve2_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h1, "reserve0_busy_t");
        expect2(K_HZ, 0, 32'h1, 32'h1, "rereserve2_hazard");
        expect2(K_A,  1, 32'h0, 32'h0, "rereserve2_outA");
        expect2(K_B,  1, 32'h0, 32'h00005678, "rereserve2_outB");
        step();
        // same-cycle read and write of 9
        drive(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0);
        expect2(K_BS, 0, BYP ? 32'h0 : 32'h1, BYP ? 32'h0 : 32'h1, "rw9_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h0, "rw9_busy_t");
        expect2(K_HZ, 0, BYP ? 32'h0 : 32'h1, BYP ? 32'h0 : 32'h1, "rw9_hazard");
        expect2(K_A,  1, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, "rw9_outA");
        expect2(K_B,  1, 32'h0, 32'h0, "rw9_outB");
        step();
        // hold: read_enabled low for 3 cycles while writing index 9
        drive(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h33, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h44, 1'b0, 5'd0);
        expect2(K_A, 0, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, "hold1_outA");
        step();
        drive(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0);
        expect2(K_A, 0, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, "hold2_outA");
        step();
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect2(K_A,  0, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, "hold3_outA");
        expect2(K_BS, 0, 32'h0, 32'h0, "hold_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h1, "hold_busy_t");
        expect2(K_HZ, 0, 32'h0, 32'h1, "hold_hazard");
        expect2(K_A,  1, 32'h55, 32'h55, "after_hold_outA");
        expect2(K_B,  1, 32'h0, 32'h00005678, "after_hold_outB");
        step();
        // same-cycle write and read of index 0
        drive(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 32'hABCD1234, 1'b0, 5'd0);
        expect2(K_BS, 0, 32'h0, BYP ? 32'h0 : 32'h1, "rw0_busy_s");
        expect2(K_BT, 0, 32'h0, 32'h0, "rw0_busy_t");
        expect2(K_HZ, 0, 32'h0, BYP ? 32'h0 : 32'h1, "rw0_hazard");
        expect2(K_A,  1, 32'h0, BYP ? 32'h00001234 : 32'h00005678, "rw0_outA");
        expect2(K_B,  1, 32'h0, 32'h0, "rw0_outB");
        step();
        idle();
        step();
        step();
        @(negedge clock);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
